// File: rtl/seg_display_scheduler.sv
// Round-robin owner of the shared 4-digit seven-segment path; holds each grant >= HOLD_CYCLES.
// Optional SEG_BLINK_EN: pulse blank for BLINK_CYCLES whenever the display changes owner.
module seg_display_scheduler #(
  parameter int          NREQ         = 4,
  parameter int          HOLD_CYCLES  = 4096,
  parameter logic [15:0] IDLE_PATTERN = 16'hFFFF,
  parameter int          BLINK_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   data_in,
  output logic [NREQ-1:0]      grant,
  output logic [15:0]          bcd_out,
  output logic                 busy,
  output logic                 blank
);

  localparam int PTR_W  = $clog2(NREQ);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t            state_r, state_s;
  logic [NREQ-1:0]   grant_r, grant_s;
  logic [15:0]       bcd_r, bcd_s;
  logic              busy_r;
  logic [HOLD_W-1:0] hold_r, hold_s;
  logic [PTR_W-1:0]  ptr_r, ptr_s;
  logic [PTR_W-1:0]  win_s, cand_s;
  logic              any_req_s;

  function automatic logic [15:0] word_at(input logic [16*NREQ-1:0] bus,
                                          input logic [PTR_W-1:0] idx);
    word_at = bus[{idx, 4'b0000} +: 16];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Winner search: first requester after ptr; the current owner is tried last
  always_comb begin
    any_req_s = |req;
    win_s     = ptr_r;
    cand_s    = ptr_r;
    for (int k = NREQ; k >= 1; k--) begin
      cand_s = PTR_W'((int'(ptr_r) + k) % NREQ);
      win_s  = req[cand_s] ? cand_s : win_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    bcd_s   = bcd_r;
    hold_s  = hold_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s = ST_GRANT;
          grant_s = onehot(win_s);
          bcd_s   = word_at(data_in, win_s);
          hold_s  = HOLD_RELOAD;
          ptr_s   = win_s;
        end else begin
          grant_s = {NREQ{1'b0}};
          bcd_s   = IDLE_PATTERN;
        end
      end
      ST_GRANT: begin
        if (hold_r != {HOLD_W{1'b0}}) begin
          hold_s = hold_r - HOLD_W'(1);
          // A dropped owner leaves its last word frozen on the display
          if (req[ptr_r]) begin
            bcd_s = word_at(data_in, ptr_r);
          end else begin
            bcd_s = bcd_r;
          end
        end else if (any_req_s) begin
          grant_s = onehot(win_s);
          bcd_s   = word_at(data_in, win_s);
          hold_s  = HOLD_RELOAD;
          ptr_s   = win_s;
        end else begin
          state_s = ST_IDLE;
          grant_s = {NREQ{1'b0}};
          bcd_s   = IDLE_PATTERN;
          hold_s  = {HOLD_W{1'b0}};
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = {NREQ{1'b0}};
        bcd_s   = IDLE_PATTERN;
        hold_s  = {HOLD_W{1'b0}};
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      grant_r <= {NREQ{1'b0}};
      bcd_r   <= IDLE_PATTERN;
      busy_r  <= 1'b0;
      hold_r  <= {HOLD_W{1'b0}};
      ptr_r   <= PTR_W'(NREQ - 1);
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      bcd_r   <= bcd_s;
      busy_r  <= (grant_s != {NREQ{1'b0}});
      hold_r  <= hold_s;
      ptr_r   <= ptr_s;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic               blank_r;
  logic [BLINK_W-1:0] blink_r;
  logic               change_s;

  assign change_s = (grant_s != {NREQ{1'b0}}) && (grant_s != grant_r);

  // Blank pulse: restarts on every owner change, lasts BLINK_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_r <= 1'b0;
      blink_r <= {BLINK_W{1'b0}};
    end else if (change_s) begin
      blank_r <= 1'b1;
      blink_r <= BLINK_W'(BLINK_CYCLES - 1);
    end else begin
      blank_r <= (blink_r != {BLINK_W{1'b0}});
      blink_r <= (blink_r != {BLINK_W{1'b0}}) ? blink_r - BLINK_W'(1) : blink_r;
    end
  end

  assign blank = blank_r;
`else
  assign blank = 1'b0;
`endif

  assign grant   = grant_r;
  assign bcd_out = bcd_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with a cycle-level behavioural model.
// Builds with or without SEG_BLINK_EN; blank expectations follow the macro.
module tb_seg_display_scheduler;

  localparam int NREQ  = 4;
  localparam int HOLD  = 8;
  localparam int BLINK = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [16*NREQ-1:0] data;
  logic [NREQ-1:0]   grant;
  logic [15:0]       bcd_out;
  logic              busy;
  logic              blank;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  seg_display_scheduler #(
    .NREQ(NREQ), .HOLD_CYCLES(HOLD), .IDLE_PATTERN(16'hFFFF), .BLINK_CYCLES(BLINK)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data),
    .grant(grant), .bcd_out(bcd_out), .busy(busy), .blank(blank)
  );

  always #5 clk = ~clk;

  // Model: owner index (-1 idle), cycles the grant has been visible, rr pointer, shown word
  typedef struct {
    int          owner;
    int          shown;
    int          ptr;
    logic [15:0] word;
    int          blink;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t step(mstate_t s, logic r, logic [NREQ-1:0] q,
                                   logic [16*NREQ-1:0] d);
    mstate_t n = s;
    int pick = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i = (s.ptr + k) % NREQ;
      if (pick < 0 && q[i]) pick = i;
    end
    if (r) begin
      n.owner = -1; n.shown = 0; n.ptr = NREQ - 1; n.word = 16'hFFFF; n.blink = 0;
      return n;
    end
    if (s.owner < 0 || s.shown == HOLD) begin
      if (pick >= 0) begin
        n.owner = pick; n.ptr = pick; n.shown = 1; n.word = d[16*pick +: 16];
      end else begin
        n.owner = -1; n.shown = 0; n.word = 16'hFFFF;
      end
    end else begin
      n.shown = s.shown + 1;
      if (q[s.owner]) n.word = d[16*s.owner +: 16];
    end
    if (n.owner >= 0 && n.owner != s.owner) n.blink = BLINK;
    else if (s.blink > 0) n.blink = s.blink - 1;
    return n;
  endfunction

  always @(posedge clk) m <= step(m, rst, req, data);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (check_en) begin
      logic [NREQ-1:0] eg;
      logic            eb;
      eg = (m.owner < 0) ? '0 : (NREQ'(1) << m.owner);
`ifdef SEG_BLINK_EN
      eb = (m.blink > 0);
`else
      eb = 1'b0;
`endif
      chk("grant", 32'(grant), 32'(eg));
      chk("bcd_out", 32'(bcd_out), 32'(m.word));
      chk("busy", 32'(busy), 32'(eg != '0));
      chk("blank", 32'(blank), 32'(eb));
      chk("onehot0", 32'($onehot0(grant)), 32'd1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [15:0] w);
    data[16*i +: 16] = w;
  endtask

  initial begin
    rst = 1'b1; req = '0; data = '0;
    tick(1);
    check_en = 1'b1;
    rst = 1'b0;
    tick(1);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_bcd", 32'(bcd_out), 32'hFFFF);
    chk("reset_busy", 32'(busy), 32'h0);

    // Single requester, data following, repeated hold expiry
    set_word(2, 16'h1234); req = 4'b0100;
    tick(1);
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_bcd", 32'(bcd_out), 32'h1234);
`ifdef SEG_BLINK_EN
    chk("single_blank", 32'(blank), 32'h1);
`endif
    set_word(2, 16'h5678);
    tick(1);
    chk("follow_bcd", 32'(bcd_out), 32'h5678);
    tick(20);
    chk("repeat_grant", 32'(grant), 32'h4);

    // Release to idle mid-hold
    req = '0;
    tick(10);
    chk("release_grant", 32'(grant), 32'h0);
    chk("release_bcd", 32'(bcd_out), 32'hFFFF);

    // Round robin from reset: each owner exactly HOLD cycles
    rst = 1'b1; tick(1); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_word(i, 16'hA000 + 16'(i));
    req = 4'b1111;
    tick(1);
    chk("rr0", 32'(grant), 32'h1);
    tick(HOLD - 1);
    chk("rr0_end", 32'(grant), 32'h1);
    tick(1);
    chk("rr1", 32'(grant), 32'h2);
    tick(HOLD);
    chk("rr2", 32'(grant), 32'h4);
    chk("rr2_bcd", 32'(bcd_out), 32'hA002);
    tick(HOLD);
    chk("rr3", 32'(grant), 32'h8);
    tick(HOLD);
    chk("rr_wrap", 32'(grant), 32'h1);

    // Early drop by owner 1 at hold count 5 with requester 3 waiting
    rst = 1'b1; req = '0; tick(1); rst = 1'b0;
    set_word(1, 16'h0042); set_word(3, 16'h0333);
    req = 4'b0010;
    tick(1);
    req = 4'b1010;
    tick(2);
    req = 4'b1000; set_word(1, 16'h0BAD);
    tick(5);
    chk("drop_frozen", 32'(bcd_out), 32'h0042);
    chk("drop_owner", 32'(grant), 32'h2);
    tick(1);
    chk("drop_next", 32'(grant), 32'h8);
    chk("drop_next_bcd", 32'(bcd_out), 32'h0333);

    // Drop all mid-hold, then reset mid-grant with everyone requesting
    tick(3);
    req = '0;
    tick(HOLD);
    chk("idle_again", 32'(grant), 32'h0);
    req = 4'b1111;
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_grant", 32'(grant), 32'h0);
    chk("rst_mid_bcd", 32'(bcd_out), 32'hFFFF);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(1);
    chk("after_rst_grant", 32'(grant), 32'h1);
    tick(3 * HOLD);
    req = '0;
    tick(2 * HOLD);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
